// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory initiator: access sizes,
// FSM states and the size-to-byte-count helper.
package mem_pkg;

    localparam logic [1:0] WS_BYTE  = 2'b00;
    localparam logic [1:0] WS_HALF  = 2'b01;
    localparam logic [1:0] WS_WORD  = 2'b10;
    localparam logic [1:0] WS_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RESP
    } state_e;

    function automatic logic [3:0] ws_nbytes(input logic [1:0] ws);
        logic [3:0] n;
        case (ws)
            WS_BYTE: n = 4'd1;
            WS_HALF: n = 4'd2;
            WS_WORD: n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_strobe_timer.sv
// Counts cycles spent in one strobe; expired is high during the limit-th
// enabled cycle so the owner can act on that same edge.
module mem_strobe_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: count_d gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + ONE;
        end
    end

    assign expired = enable && (count_q == (limit - ONE));

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values; rst_n is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Initiator side of the Mov/Moc handshake: splits CPU loads/stores into
// big-endian single-byte memory transactions and assembles read data.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int WR_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_ws,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        Mov,
    output logic        RW,
    output logic [7:0]  Address,
    output logic [1:0]  ws,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut,
    input  logic        Moc
);

    localparam int TMAX = (TIMEOUT > WR_CYCLES) ? TIMEOUT : WR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RD_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0] WR_LIMIT = TW'(WR_CYCLES);

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  k_q, k_d;
    logic [7:0]  addr_q, addr_d;
    logic [63:0] wshift_q, wshift_d;
    logic [63:0] accum_q, accum_d;
    logic        err_q, err_d;

    logic [3:0]    req_n;
    logic [3:0]    k_inc;
    logic          byte_done;
    logic          tmr_enable;
    logic          tmr_clear;
    logic          tmr_expired;
    logic [TW-1:0] tmr_limit;
    logic          data_out_unused;

    assign data_out_unused = ^DataOut[31:8];
    assign req_n           = ws_nbytes(req_ws);
    assign k_inc           = k_q + 4'd1;
    assign tmr_enable      = (state_q == STROBE);
    assign tmr_clear       = !tmr_enable;
    assign tmr_limit       = rw_q ? RD_LIMIT : WR_LIMIT;

    mem_strobe_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        n_d       = n_q;
        k_d       = k_q;
        addr_d    = addr_q;
        wshift_d  = wshift_q;
        accum_d   = accum_q;
        err_d     = err_q;
        byte_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rw_d    = req_rw;
                    n_d     = req_n;
                    k_d     = 4'd0;
                    addr_d  = req_addr;
                    accum_d = '0;
                    err_d   = 1'b0;
                    // Left-justify the store value so its MSB leaves first.
                    wshift_d = req_rw ? '0 : (req_wdata << {4'd8 - req_n, 3'b000});
                    state_d = SETUP;
                end
            end

            SETUP: begin
                state_d = STROBE;
            end

            STROBE: begin
                if (rw_q) begin
                    // Moc is tested ahead of expiry so a coincident Moc succeeds.
                    if (Moc) begin
                        accum_d   = {accum_q[55:0], DataOut[7:0]};
                        byte_done = 1'b1;
                    end else if (tmr_expired) begin
                        err_d   = 1'b1;
                        accum_d = '0;
                        state_d = RESP;
                    end
                end else if (tmr_expired) begin
                    wshift_d  = {wshift_q[55:0], 8'h00};
                    byte_done = 1'b1;
                end

                if (byte_done) begin
                    k_d     = k_inc;
                    addr_d  = addr_q + 8'd1;
                    state_d = (k_inc == n_q) ? RESP : SETUP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rw_q     <= 1'b1;
            n_q      <= 4'd0;
            k_q      <= 4'd0;
            addr_q   <= 8'd0;
            wshift_q <= '0;
            accum_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            n_q      <= n_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            wshift_q <= wshift_d;
            accum_q  <= accum_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && rw_q && !err_q) ? accum_q : '0;

    assign Mov     = (state_q == STROBE);
    assign RW      = rw_q;
    assign Address = addr_q;
    assign ws      = WS_BYTE;
    assign DataIn  = {24'h000000, wshift_q[63:56]};

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: a byte-array memory answers the
// handshake while a request-level model predicts strobes and responses.
module tb_mem_initiator;

    localparam int TIMEOUT   = 16;
    localparam int WR_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_ws;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        Mov;
    logic        RW;
    logic [7:0]  Address;
    logic [1:0]  ws;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Moc;

    mem_initiator #(
        .TIMEOUT   (TIMEOUT),
        .WR_CYCLES (WR_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_ws     (req_ws),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .Mov        (Mov),
        .RW         (RW),
        .Address    (Address),
        .ws         (ws),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .Moc        (Moc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- memory model seen by the DUT ----------------
    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29) + 7);
    endfunction

    logic [7:0] mem [256];
    logic       moc_en = 1'b1;
    logic       moc_force = 1'b0;
    int         moc_delay = 0;
    int         age = 0;

    always @(posedge clk) begin
        if (Mov) age <= age + 1;
        else     age <= 0;
        if (cyc < 2) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (Mov && !RW) begin
            mem[Address] <= DataIn[7:0];
        end
    end

    assign Moc     = moc_force || (Mov && moc_en && (age >= moc_delay));
    assign DataOut = {24'hA5A5A5, mem[Address]};

    // ---------------- reference model and scoreboards ----------------
    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    resp_t      resp_q[$];
    strobe_t    strb_q[$];
    logic [7:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    end

    // Request-level view: n bytes, big-endian, lowest address first.
    // Each read byte costs SETUP + (delay+1) strobe cycles, each write byte
    // SETUP + WR_CYCLES; a read byte that never sees Moc costs SETUP + TIMEOUT.
    task automatic model(input logic rw, input logic [1:0] wsz, input logic [7:0] addr,
                         input logic [63:0] wdata, output int lat, output logic err,
                         output logic [63:0] rdata);
        int         n;
        int         dly;
        bit         moc_on;
        logic [7:0] a;
        logic [7:0] b;
        n      = 1 << wsz;
        moc_on = moc_force || moc_en;
        dly    = moc_force ? 0 : moc_delay;
        lat    = 1;
        err    = 1'b0;
        rdata  = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            if (!rw) begin
                b = wdata[8*(n-1-i) +: 8];
                strb_q.push_back('{1'b0, a, b});
                ref_mem[a] = b;
                lat += 1 + WR_CYCLES;
            end else begin
                strb_q.push_back('{1'b1, a, 8'h00});
                if (moc_on && dly < TIMEOUT) begin
                    rdata = (rdata << 8) | 64'(ref_mem[a]);
                    lat += 2 + dly;
                end else begin
                    err   = 1'b1;
                    rdata = '0;
                    lat += 1 + TIMEOUT;
                    break;
                end
            end
        end
    endtask

    // Strobe monitor: one expected entry per Mov rise; signals held while Mov=1.
    strobe_t    exp_s;
    logic       mov_prev = 1'b0;
    logic [7:0] held_addr;
    logic       held_rw;
    logic [31:0] held_din;

    always @(negedge clk) begin
        if (Mov && !mov_prev) begin
            check("ws_byte", 64'(ws), 64'(0));
            check("datain_upper_zero", 64'(DataIn[31:8]), 64'(0));
            if (strb_q.size() == 0) begin
                fail("spurious_strobe", $sformatf("strobe at addr 0x%0h, required none", Address));
            end else begin
                exp_s = strb_q.pop_front();
                check("strobe_rw", 64'(RW), 64'(exp_s.rw));
                check("strobe_addr", 64'(Address), 64'(exp_s.addr));
                if (!exp_s.rw) check("strobe_wdata", 64'(DataIn[7:0]), 64'(exp_s.data));
            end
            held_addr = Address;
            held_rw   = RW;
            held_din  = DataIn;
        end else if (Mov) begin
            check("strobe_addr_stable", 64'(Address), 64'(held_addr));
            check("strobe_rw_stable", 64'(RW), 64'(held_rw));
            check("strobe_din_stable", 64'(DataIn), 64'(held_din));
        end
        mov_prev = Mov;
    end

    // Response monitor.
    resp_t mon_e;
    bit    post_resp = 1'b0;

    always @(negedge clk) begin
        if (post_resp) begin
            check("resp_one_cycle", 64'(resp_valid), 64'(0));
            check("ready_after_resp", 64'(req_ready), 64'(1));
            post_resp = 1'b0;
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                fail("unexpected_resp", $sformatf("resp_valid with rdata 0x%0h, required no response", resp_rdata));
            end else begin
                mon_e = resp_q.pop_front();
                check("resp_err", 64'(resp_err), 64'(mon_e.err));
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("mov_low_in_resp", 64'(Mov), 64'(0));
                check("not_ready_in_resp", 64'(req_ready), 64'(0));
                post_resp = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) fail("ready_timeout", "req_ready=0 after 400 cycles, required 1");
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (resp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (resp_q.size() != 0) begin
            fail("resp_timeout", "no resp_valid within 400 cycles, required a response");
            resp_q.delete();
            strb_q.delete();
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic drive_req(input logic rw, input logic [1:0] wsz, input logic [7:0] addr,
                             input logic [63:0] wdata);
        wait_ready();
        req_rw    = rw;
        req_ws    = wsz;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic rw, input logic [1:0] wsz, input logic [7:0] addr,
                              input logic [63:0] wdata, input bit use_exp,
                              input logic [63:0] exp_rd, output int lat);
        logic        err;
        logic [63:0] rd;
        model(rw, wsz, addr, wdata, lat, err, rd);
        if (use_exp) rd = exp_rd;
        resp_q.push_back('{err, rd, cyc + lat - 1});
    endtask

    task automatic issue(input logic rw, input logic [1:0] wsz, input logic [7:0] addr,
                         input logic [63:0] wdata, input bit use_exp, input logic [63:0] exp_rd);
        int lat;
        drive_req(rw, wsz, addr, wdata);
        req_valid = 1'b0;
        expect_req(rw, wsz, addr, wdata, use_exp, exp_rd, lat);
        wait_done();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat_a;
        int          lat_b;
        int          seen;
        int          mode;
        logic        err_x;
        logic [63:0] rd_x;

        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_ws    = 2'b00;
        req_addr  = 8'h00;
        req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_err", 64'(resp_err), 64'(0));
        check("rst_resp_rdata", resp_rdata, 64'(0));
        check("rst_mov", 64'(Mov), 64'(0));
        check("rst_rw", 64'(RW), 64'(1));
        check("rst_address", 64'(Address), 64'(0));
        check("rst_ws", 64'(ws), 64'(0));
        check("rst_datain", 64'(DataIn), 64'(0));
        rst_n = 1'b1;

        // Word store then loads of the same bytes.
        issue(1'b0, 2'b10, 8'h10, 64'h00000000DEADBEEF, 1'b0, '0);
        issue(1'b1, 2'b10, 8'h10, '0, 1'b1, 64'h00000000DEADBEEF);
        issue(1'b1, 2'b01, 8'h11, '0, 1'b1, 64'h000000000000ADBE);

        // Doubleword across the 0xFF -> 0x00 wrap.
        issue(1'b0, 2'b11, 8'hFC, 64'h0102030405060708, 1'b0, '0);
        issue(1'b1, 2'b11, 8'hFC, '0, 1'b1, 64'h0102030405060708);
        issue(1'b1, 2'b00, 8'hFF, '0, 1'b1, 64'h0000000000000004);

        // Read with Moc never asserted times out.
        moc_en = 1'b0;
        issue(1'b1, 2'b10, 8'h40, '0, 1'b0, '0);
        moc_en = 1'b1;

        // Moc on the last allowed cycle succeeds; one later times out.
        moc_delay = TIMEOUT - 1;
        issue(1'b1, 2'b01, 8'h12, '0, 1'b1, 64'h000000000000BEEF);
        moc_delay = TIMEOUT;
        issue(1'b1, 2'b01, 8'h12, '0, 1'b0, '0);
        moc_delay = 0;

        // Moc stuck high, including through SETUP, must not add bytes.
        moc_force = 1'b1;
        issue(1'b1, 2'b10, 8'h10, '0, 1'b1, 64'h00000000DEADBEEF);
        moc_force = 1'b0;

        // req_valid held with a different address while busy.
        drive_req(1'b1, 2'b10, 8'h10, '0);
        expect_req(1'b1, 2'b10, 8'h10, '0, 1'b1, 64'h00000000DEADBEEF, lat_a);
        req_ws   = 2'b00;
        req_addr = 8'h13;
        repeat (lat_a + 1) @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_req(1'b1, 2'b00, 8'h13, '0, 1'b1, 64'h00000000000000EF, lat_b);
        wait_done();

        // Reset one edge after the third byte of a doubleword read.
        drive_req(1'b1, 2'b11, 8'h20, '0);
        req_valid = 1'b0;
        model(1'b1, 2'b11, 8'h20, '0, lat_a, err_x, rd_x);
        while (strb_q.size() > 3) void'(strb_q.pop_back());
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_mov", 64'(Mov), 64'(0));
        check("abort_ready", 64'(req_ready), 64'(1));
        check("abort_rw", 64'(RW), 64'(1));
        check("abort_address", 64'(Address), 64'(0));
        check("abort_strobes", 64'(strb_q.size()), 64'(0));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort_no_resp", 64'(seen), 64'(0));

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 9));
            moc_en    = (mode != 0);
            moc_force = (mode == 3);
            moc_delay = (mode == 1 || mode == 2) ? int'($urandom_range(1, 4)) : 0;
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  {$urandom, $urandom}, 1'b0, '0);
        end
        moc_en    = 1'b1;
        moc_force = 1'b0;
        moc_delay = 0;

        repeat (4) @(negedge clk);
        check("resp_queue_empty", 64'(resp_q.size()), 64'(0));
        check("strobe_queue_empty", 64'(strb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
